left_shift: RTL and testbench
=============================

LEFT_SHIFT -- requirements
Module: left_shift

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; WIDTH SHALL be a power of two, 8 to 64.
REQ-002 Parameter DEFAULT_SHIFT, default 2, fixed shift amount used when use_shamt=0 (branch/jump offset word-to-byte scaling).
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high, sampled on rising clk.
REQ-005 Port in  input  WIDTH  operand to be shifted.
REQ-006 Port in_valid  input  1  operand qualifier; in, shamt and use_shamt are captured only when in_valid=1.
REQ-007 Port use_shamt  input  1  1 = shift by shamt, 0 = shift by DEFAULT_SHIFT.
REQ-008 Port shamt  input  log2(WIDTH)  variable shift amount, unsigned, 0..WIDTH-1.
REQ-009 Port out  output  WIDTH  registered result.
REQ-010 Port out_valid  output  1  high for one cycle per accepted operand.
REQ-011 Port ovf  output  1  registered; high when any 1 bit was shifted out past the MSB.

Function
REQ-012 Effective shift s SHALL be shamt when use_shamt=1, else DEFAULT_SHIFT.
REQ-013 Result SHALL be logical left shift: out = (in << s) truncated to WIDTH bits; vacated LSBs zero-filled.
REQ-014 ovf SHALL be 1 iff in[WIDTH-1 : WIDTH-s] contains any 1; ovf SHALL be 0 when s=0.
REQ-015 Shifter SHALL be a log2(WIDTH)-stage barrel shifter (stage k shifts by 2^k when s bit k set), combinational within one cycle.
REQ-016 Latency SHALL be exactly 1 cycle: operand accepted at edge N appears on out/ovf with out_valid=1 after edge N.
REQ-017 Throughput SHALL be one operand per cycle; back-to-back in_valid=1 SHALL yield back-to-back out_valid=1 with no bubbles.
REQ-018 When in_valid=0 at an edge, out_valid SHALL go 0 and out/ovf SHALL hold their previous values.
REQ-019 No backpressure: no ready signal; consumer SHALL take the result while out_valid=1.
REQ-020 s=0 SHALL pass in through unchanged with ovf=0.
REQ-021 Unknown/X on in while in_valid=0 SHALL NOT affect any output.

Reset
REQ-022 While rst=1 at a rising edge, out SHALL become 0, ovf 0, out_valid 0, regardless of in_valid.
REQ-023 rst SHALL take priority over a simultaneous in_valid=1; that operand SHALL be discarded (no out_valid after reset release).
REQ-024 First operand accepted on the first edge with rst=0 SHALL produce out_valid on the following cycle per REQ-016.

Verification
REQ-025 rst=1 two cycles, then in=0x0000_3000, in_valid=1, use_shamt=0 -> next cycle out=0x0000_C000, ovf=0, out_valid=1.
REQ-026 in=0x0000_400F, use_shamt=0, in_valid=1 -> out=0x0001_003C, ovf=0, out_valid=1.
REQ-027 in=0xC000_0001, use_shamt=0 -> out=0x0000_0004, ovf=1; in=0x8000_0000, use_shamt=1, shamt=31 -> out=0x0000_0000, ovf=1.
REQ-028 in=0x1234_5678, use_shamt=1, shamt=0 -> out=0x1234_5678, ovf=0; shamt=4 -> out=0x2345_6780, ovf=1.
REQ-029 Back-to-back stream of 3 operands then in_valid=0 -> out_valid high exactly 3 consecutive cycles, then 0 with out holding last result.
REQ-030 Assert rst on same edge as in_valid=1, in=0xFFFF_FFFF -> out=0, ovf=0, out_valid=0 next cycle and no later out_valid for that operand.

Source files
------------

// File: rtl/left_shift.sv
// ---------------------------------------------------------------------------
// left_shift
//
// Purpose
//   Registered logical left shifter with overflow detection. Used for
//   scaling word offsets to byte offsets: use_shamt=0 applies the fixed
//   DEFAULT_SHIFT. use_shamt=1 applies the variable amount on shamt.
//   The shift is a log2(WIDTH)-stage barrel shifter that settles within
//   one cycle. The result is registered, so latency is exactly one cycle
//   and throughput is one operand per cycle.
//
// Parameters
//   WIDTH          data width in bits (power of two, 8..64)
//   DEFAULT_SHIFT  shift amount used when use_shamt=0 (0..WIDTH-1)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in         in   operand to be shifted
//   in_valid   in   qualifies in / shamt / use_shamt for capture
//   use_shamt  in   1 = shift by shamt, 0 = shift by DEFAULT_SHIFT
//   shamt      in   variable shift amount, unsigned
//   out        out  registered shifted result
//   out_valid  out  high for one cycle per accepted operand
//   ovf        out  registered; a 1 bit was shifted out past the MSB
//
// Handshake
//   in_valid is a one-way qualifier with no ready. Every cycle with
//   in_valid=1 (and rst=0) is an accepted operand. Its result appears on
//   out/ovf with out_valid=1 in the next cycle. The consumer must take
//   the result in that cycle. While no operand is accepted, out_valid
//   is 0 and out/ovf hold the last result.
// ---------------------------------------------------------------------------
module left_shift #(
  parameter int WIDTH         = 32,
  parameter int DEFAULT_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     in_valid,
  input  logic                     use_shamt,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic                     ovf
);

  localparam int SW = $clog2(WIDTH);

  // Fixed shift amount, narrowed to the width of the shift control.
  localparam logic [SW-1:0] DEF_S = SW'(DEFAULT_SHIFT);

  // -------------------------------------------------------------------------
  // Effective shift amount
  // -------------------------------------------------------------------------
  logic [SW-1:0] eff_s;

  assign eff_s = use_shamt ? shamt : DEF_S;

  // -------------------------------------------------------------------------
  // Barrel shifter
  //   stg_val[0] is the operand. Stage k shifts by 2^k when bit k of the
  //   effective amount is set.
  //   Overflow is built up stage by stage. A stage that shifts by 2^k
  //   drops the top 2^k bits of its input. Over all stages, exactly the
  //   top s bits of the original operand are dropped. So the OR of the
  //   dropped bits equals "any 1 in in[WIDTH-1 : WIDTH-s]". For s=0 no
  //   stage is active, so this is 0.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] stg_val [SW+1];
  logic [SW:0]      stg_ovf;

  assign stg_val[0] = in;
  assign stg_ovf[0] = 1'b0;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int STEP = 1 << k;

    logic [STEP-1:0] dropped;

    assign dropped        = stg_val[k][WIDTH-1 -: STEP];
    assign stg_val[k+1]   = eff_s[k] ? (stg_val[k] << STEP) : stg_val[k];
    assign stg_ovf[k+1]   = stg_ovf[k] | (eff_s[k] & (|dropped));
  end

  // -------------------------------------------------------------------------
  // Output register
  //   Reset wins over a simultaneous operand, and that operand is dropped.
  //   The data and overflow registers load only on an accepted operand.
  //   So unknown data on in while in_valid=0 never reaches them.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] out_q,       out_d;
  logic             ovf_q,       ovf_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    out_d       = out_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = stg_val[SW];
      ovf_d       = stg_ovf[SW];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_left_shift.sv
// ---------------------------------------------------------------------------
// tb_left_shift
//
// Self-checking bench for left_shift (WIDTH=32, DEFAULT_SHIFT=2).
//
// The reference model works on a 64-bit widening of the operand:
//   - the low 32 bits of (operand << s) give the result;
//   - any nonzero upper bit means a 1 crossed the MSB.
// Expected results are pushed into exp_q when an operand is accepted.
// They are popped one cycle later, when out_valid is expected.
// ---------------------------------------------------------------------------
module tb_left_shift;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int DS = 2;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_d;
  logic          in_valid;
  logic          use_shamt;
  logic [SW-1:0] shamt;
  logic [W-1:0]  dut_out;
  logic          dut_out_valid;
  logic          dut_ovf;

  always #5 clk = ~clk;

  left_shift #(
    .WIDTH         (W),
    .DEFAULT_SHIFT (DS)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_d),
    .in_valid  (in_valid),
    .use_shamt (use_shamt),
    .shamt     (shamt),
    .out       (dut_out),
    .out_valid (dut_out_valid),
    .ovf       (dut_ovf)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [W:0] exp_q [$];   // {ovf, out}
  logic [W-1:0] m_out;     // model of the held output value
  logic         m_ovf;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: widen to 64 bits, shift, split into result and overflow.
  function automatic logic [W:0] ref_shift(input logic [W-1:0] d,
                                           input int s);
    logic [63:0] wide;
    wide = {32'd0, d} << s;
    return {(wide[63:32] != 32'd0), wide[31:0]};
  endfunction

  // -------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, clock it, then check outputs.
  // -------------------------------------------------------------------------
  task automatic step(input logic r, input logic v, input logic us,
                      input logic [SW-1:0] sh, input logic [W-1:0] d);
    logic [W:0] e;
    logic       exp_valid;
    rst       = r;
    in_valid  = v;
    use_shamt = us;
    shamt     = sh;
    in_d      = d;
    if (!r && v) exp_q.push_back(ref_shift(d, us ? int'(sh) : DS));
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (r) begin
      exp_q.delete();
      m_out = '0;
      m_ovf = 1'b0;
    end else if (v) begin
      e         = exp_q.pop_front();
      m_out     = e[W-1:0];
      m_ovf     = e[W];
      exp_valid = 1'b1;
    end
    check_eq("out_valid", 64'(dut_out_valid), 64'(exp_valid));
    check_eq("out",       64'(dut_out),       64'(m_out));
    check_eq("ovf",       64'(dut_ovf),       64'(m_ovf));
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [W-1:0] d;
    m_out     = '0;
    m_ovf     = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    use_shamt = 1'b0;
    shamt     = '0;
    in_d      = '0;

    // Two reset cycles, then the directed vectors.
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0000_3000);
    check_eq("dir_3000", 64'(dut_out), 64'h0000_C000);
    step(0, 1, 0, 0, 32'h0000_400F);
    check_eq("dir_400F", 64'(dut_out), 64'h0001_003C);
    step(0, 1, 0, 0, 32'hC000_0001);
    check_eq("dir_C001", 64'({dut_ovf, dut_out}), 64'h1_0000_0004);
    step(0, 1, 1, 31, 32'h8000_0000);
    check_eq("dir_s31", 64'({dut_ovf, dut_out}), 64'h1_0000_0000);
    step(0, 1, 1, 0, 32'h1234_5678);
    check_eq("dir_s0", 64'({dut_ovf, dut_out}), 64'h0_1234_5678);
    step(0, 1, 1, 4, 32'h1234_5678);
    check_eq("dir_s4", 64'({dut_ovf, dut_out}), 64'h1_2345_6780);

    // Three back-to-back operands, then idle with changing input data.
    step(0, 1, 1, 1,  32'h0000_0001);
    step(0, 1, 1, 7,  32'h0100_00FF);
    step(0, 1, 0, 0,  32'h4000_0000);
    step(0, 0, 1, 3,  32'hDEAD_BEEF);
    step(0, 0, 0, 9,  32'hFFFF_FFFF);
    check_eq("hold_last", 64'(dut_out), 64'h0000_0000);
    check_eq("hold_ovf",  64'(dut_ovf), 64'h1);

    // Input data changes while in_valid=0 must not disturb outputs.
    for (int i = 0; i < 4; i++) step(0, 0, $urandom_range(0, 1), 5'($urandom), $urandom);

    // Reset coincides with an operand: that operand is dropped.
    step(0, 1, 0, 0, 32'h0000_0005);
    step(1, 1, 0, 0, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    check_eq("rst_drop_out", 64'(dut_out), 64'h0);

    // Randomized traffic, including walking edge cases of the shift amount.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'h1 << $urandom_range(0, 31);
        default: d = $urandom;
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
           $urandom_range(0, 1), 5'($urandom_range(0, 31)), d);
    end

    // Drain.
    step(0, 0, 0, 0, 32'h0);
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
